// File: rtl/ame_sobel_sched.sv
// ame_sobel_sched: scheduler for the shared 6-cycle Sobel engine.
// Round-robin arbitration between horizontal (req 0) and vertical (req 1) jobs.
// For each job it issues six line-buffer reads and kicks the engine. It then
// captures the engine result on eng_done_i and holds it in a valid/ready register.
// Optional watchdog on the engine done pulse: define AME_SOBEL_SCHED_WDT_EN.
module ame_sobel_sched #(
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8,
  parameter int ADDR_BITS      = 10,
  parameter int ADDR_STRIDE    = 1,
  parameter int WDT_CYCLES     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    req_i,
  input  logic [2*ADDR_BITS-1:0]        req_addr_i,
  output logic [1:0]                    gnt_o,
  output logic                          busy_o,
  output logic                          mem_rd_en_o,
  output logic                          mem_rd_sel_o,
  output logic [ADDR_BITS-1:0]          mem_rd_addr_o,
  input  logic [6*LINE_DATA_BITS-1:0]   mem_rd_data_i,
  output logic                          eng_init_o,
  output logic [6*LINE_DATA_BITS-1:0]   eng_line_data_o,
  input  logic                          eng_done_i,
  input  logic [16*COMP_DATA_BITS-1:0]  eng_data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_dir_o,
  output logic [16*COMP_DATA_BITS-1:0]  res_data_o,
  output logic                          err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  localparam logic [ADDR_BITS-1:0] LP_STRIDE = ADDR_BITS'(ADDR_STRIDE);

  state_t                         r_state;
  logic                           r_rr;       // last granted requester
  logic [2:0]                     r_k;        // line index within ISSUE
  logic                           r_dir;
  logic [1:0]                     r_gnt;
  logic                           r_busy;
  logic                           r_rd_en;
  logic                           r_rd_sel;
  logic [ADDR_BITS-1:0]           r_rd_addr;
  logic                           r_init;
  logic                           r_res_valid;
  logic                           r_res_dir;
  logic [16*COMP_DATA_BITS-1:0]   r_res_data;

  logic                           w_any;
  logic                           w_win;
  logic                           w_start;
  logic [ADDR_BITS-1:0]           w_base;

`ifdef AME_SOBEL_SCHED_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0]               r_wdt;
  logic                           r_err;
  assign err_o = r_err;
`else
  logic                           w_unused_wdt;
  assign w_unused_wdt = (WDT_CYCLES != 0);
  assign err_o        = 1'b0;
`endif

  // Arbitration: on a tie the requester not granted last wins.
  always_comb begin
    w_any = |req_i;
    if (req_i == 2'b11) w_win = ~r_rr;
    else                w_win = req_i[1];
    w_base = w_win ? req_addr_i[2*ADDR_BITS-1:ADDR_BITS] : req_addr_i[ADDR_BITS-1:0];
  end

  // A handshake in HOLD doubles as the IDLE decision cycle, so back-to-back
  // jobs keep the 9-cycle grant-to-grant period.
  assign w_start = w_any && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready_i));

  // Job FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b1;
      r_k         <= '0;
      r_dir       <= 1'b0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_rd_addr   <= '0;
      r_init      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_dir   <= 1'b0;
      r_res_data  <= '0;
`ifdef AME_SOBEL_SCHED_WDT_EN
      r_wdt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_gnt  <= '0;
      r_init <= 1'b0;
`ifdef AME_SOBEL_SCHED_WDT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: ;
        S_ISSUE: begin
          if (r_k == 3'd5) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_k       <= '0;
            r_state   <= S_WAIT;
`ifdef AME_SOBEL_SCHED_WDT_EN
            r_wdt     <= '0;
`endif
          end else begin
            r_k       <= r_k + 3'd1;
            r_rd_addr <= r_rd_addr + LP_STRIDE;
          end
        end
        S_WAIT: begin
          // The engine clears its data the cycle after done, so capture now.
          if (eng_done_i) begin
            r_res_data  <= eng_data_i;
            r_res_valid <= 1'b1;
            r_res_dir   <= r_dir;
            r_state     <= S_HOLD;
          end
`ifdef AME_SOBEL_SCHED_WDT_EN
          else if (r_wdt == WDT_W'(WDT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wdt <= r_wdt + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start) begin
        r_gnt     <= w_win ? 2'b10 : 2'b01;
        r_init    <= 1'b1;
        r_rd_en   <= 1'b1;
        r_rd_addr <= w_base;
        r_rd_sel  <= w_win;
        r_dir     <= w_win;
        r_rr      <= w_win;
        r_k       <= '0;
        r_busy    <= 1'b1;
        r_state   <= S_ISSUE;
      end
    end
  end

  assign gnt_o           = r_gnt;
  assign busy_o          = r_busy;
  assign mem_rd_en_o     = r_rd_en;
  assign mem_rd_sel_o    = r_rd_sel;
  assign mem_rd_addr_o   = r_rd_addr;
  assign eng_init_o      = r_init;
  assign eng_line_data_o = mem_rd_data_i;
  assign res_valid_o     = r_res_valid;
  assign res_dir_o       = r_res_dir;
  assign res_data_o      = r_res_data;

endmodule
